mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory of the multicycle core between two requesters.
//  Requester 0 is the CPU (fetch and LDR/STR); requester 1 is the DMA/program loader.
//  Serialises accesses, holds address and data stable for the fixed memory latency,
//  and returns a one-cycle ack with read data. The CPU stalls its FSM until it sees the ack.
// PARAMETERS
//  AW   32  address width (byte address, passed through unchanged)
//  DW   32  data width
//  LAT  2   memory access cycles, mem_en held for LAT cycles; legal range 1..15
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  cpu_req    in   1   CPU request; held until cpu_ack
//  cpu_we     in   1   1 = write, 0 = read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_ack    out  1   one-cycle pulse when the CPU transaction completes
//  cpu_rdata  out  DW  read data, valid while cpu_ack=1 and held until the next CPU read completes
//  dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata   same as cpu_*, for the DMA/loader
//  mem_en     out  1   memory enable
//  mem_we     out  1   memory write enable (only asserted together with mem_en)
//  mem_addr   out  AW  latched address
//  mem_wdata  out  DW  latched write data
//  mem_rdata  in   DW  memory read data, valid in the last mem_en cycle
//  busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=DMA, cnt=0; all outputs 0 (including *_rdata and mem_addr).
//  Reset mid-transaction: the transaction is discarded; mem_en drops asynchronously; no ack is issued.
//  FSM states:
//   IDLE
//    - No request: stay in IDLE.
//    - One request: grant it. Latch addr, we and wdata; set cnt=LAT-1; go to ACCESS.
//    - Both requests: round-robin, grant the requester that is NOT last_grant.
//   ACCESS
//    - Outputs: mem_en=1, mem_we=latched we, address and data from the latch registers.
//    - cnt decrements each cycle.
//    - At cnt==0, on a read, capture mem_rdata into the granted requester's rdata register.
//    - At cnt==0, go to RESP.
//   RESP
//    - Pulse the granted requester's ack; update last_grant; go to IDLE.
//  Timing: request seen in IDLE at cycle 0 -> mem_en in cycles 1..LAT -> ack in cycle LAT+1.
//   Back-to-back transactions therefore have a period of LAT+2 cycles.
//  Request inputs are sampled only in IDLE.
//   If a requester drops req mid-transaction, the transaction still completes and the ack is still pulsed.
//  A req still high in the cycle after its ack is treated as a new transaction.
//  The non-granted requester sees no ack and its rdata is unchanged.
//  Writes leave rdata unchanged.
//  cpu_ack and dma_ack are never high in the same cycle.
//  The address is not checked; wrap-around is the memory's responsibility.
// CONFIGURATION
//  MEM_ARB_CPU_PRIORITY_EN
//   - Defined: fixed priority; the CPU always wins when both requesters are active.
//     last_grant is not used, and the DMA can be starved indefinitely.
//   - Undefined (default): round-robin as above; each requester waits at most one foreign transaction.
// STRUCTURE
//  Package mem_arb_pkg:
//   - arb_state_t enum {IDLE, ACCESS, RESP}
//   - grant_t enum {GNT_CPU, GNT_DMA}
//   - localparam CNT_W=4
//  Sub-module mem_arb_lat_counter: loadable down-counter (load value LAT-1, en, zero flag).
//  The rest (FSM, pick logic, latch registers) stays in the top module.
// TESTING
//  (all with LAT=2)
//  1. CPU read, addr=0x10, memory returns 0xE3A0_0001
//     -> mem_en high in cycles 1-2, cpu_ack in cycle 3, cpu_rdata=0xE3A0_0001.
//  2. DMA write, addr=0x40, wdata=0xDEAD_BEEF
//     -> mem_we=1 for 2 cycles with that address and data, dma_ack in cycle 3, dma_rdata unchanged.
//  3. Both requesting from reset -> CPU granted first, DMA second; acks at cycles 3 and 7.
//     With MEM_ARB_CPU_PRIORITY_EN and CPU req held high -> DMA never acked.
//  4. cpu_req dropped in cycle 1 -> access still completes and cpu_ack still pulses in cycle 3.
//  5. reset asserted in cycle 2 of ACCESS -> mem_en=0 immediately, no ack.
//     After release, a CPU read completes normally in 3 cycles.
//  6. Back-to-back CPU reads with req held high -> acks at cycles 3, 7, 11; never two ack cycles in a row.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_DMA
  } grant_t;

endpackage

// File: rtl/mem_arb_lat_counter.sv
// Loadable down-counter that times the memory access window.
// Loads LAT-1 on a new grant, counts down while enabled and holds at zero.
module mem_arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LAT - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU, DMA/loader) arbiter for the single unified memory.
// Build option: MEM_ARB_CPU_PRIORITY_EN selects fixed CPU priority instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t    state;
  arb_state_t    state_nxt;
  grant_t        grant;
  grant_t        pick;
  logic          start;
  logic          cnt_zero;
  logic          rd_capture;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

`ifdef MEM_ARB_CPU_PRIORITY_EN
  assign pick = cpu_req ? GNT_CPU : GNT_DMA;
`else
  grant_t last_grant;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    if (cpu_req && dma_req) begin
      pick = (last_grant == GNT_CPU) ? GNT_DMA : GNT_CPU;
    end else begin
      pick = cpu_req ? GNT_CPU : GNT_DMA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GNT_DMA;
    end else if (state == RESP) begin
      last_grant <= grant;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mem_arb_lat_counter #(
    .LAT (LAT)
  ) u_lat_counter (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .en    (state == ACCESS),
    .zero  (cnt_zero)
  );

  // NOTE: the request latches and read-data registers are reset because the
  // memory-side and rdata outputs are required to read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= GNT_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (start) begin
      grant     <= pick;
      lat_we    <= (pick == GNT_CPU) ? cpu_we    : dma_we;
      lat_addr  <= (pick == GNT_CPU) ? cpu_addr  : dma_addr;
      lat_wdata <= (pick == GNT_CPU) ? cpu_wdata : dma_wdata;
    end
  end

  // Read data is valid in the last access cycle; writes never touch rdata.
  assign rd_capture = (state == ACCESS) && cnt_zero && !lat_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if (rd_capture) begin
      if (grant == GNT_CPU) begin
        cpu_rdata <= mem_rdata;
      end else begin
        dma_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_ack   = (state == RESP) && (grant == GNT_CPU);
  assign dma_ack   = (state == RESP) && (grant == GNT_DMA);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (LAT=2): vector table, corner sequences
// and a randomized run against a transaction-level timing model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hE3A0_0001 : a * 32'd3 + 32'd1;
  endfunction

  assign mem_rdata = mem_en ? mem_fn(mem_addr) : 32'h0;

  typedef struct {
    bit          rst;
    bit          creq;
    bit          cwe;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    bit          dreq;
    bit          dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    int          n;
    logic [31:0] en_m;
    logic [31:0] we_m;
    logic [31:0] ca_m;
    logic [31:0] da_m;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [31:0] crd;
    logic [31:0] drd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = 32'h0;
    dma_wdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge with the cycle-0 inputs applied; records n cycles as bit masks.
  task automatic run_seq(input int n, input bit cpu_hold, input bit dma_hold, input int cpu_drop_at,
                         output logic [31:0] en_t, output logic [31:0] we_t,
                         output logic [31:0] ca_t, output logic [31:0] da_t,
                         output logic [31:0] addr1, output logic [31:0] wdata1);
    en_t = '0; we_t = '0; ca_t = '0; da_t = '0; addr1 = '0; wdata1 = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      en_t[k] = mem_en;
      we_t[k] = mem_we;
      ca_t[k] = cpu_ack;
      da_t[k] = dma_ack;
      if (k == 1) begin
        addr1  = mem_addr;
        wdata1 = mem_wdata;
      end
      if (k == cpu_drop_at) cpu_req = 1'b0;
      if (cpu_ack && !cpu_hold) cpu_req = 1'b0;
      if (dma_ack && !dma_hold) dma_req = 1'b0;
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] en_t, we_t, ca_t, da_t, a1, w1;
    logic [31:0] acc;
    int          acc_start, ack_at, free_at;
    bit          g, last_dma, m_we, c_pend, d_pend, exp_en, exp_ca, exp_da;
    logic [31:0] m_addr, m_wdata, exp_crd, exp_drd;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 6,
                32'h06, 32'h00, 32'h08, 32'h00, 32'h10, 32'h0, 32'hE3A0_0001, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 6,
                32'h06, 32'h06, 32'h00, 32'h08, 32'h40, 32'hDEAD_BEEF, 32'hE3A0_0001, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0, 6,
                32'h06, 32'h06, 32'h08, 32'h00, 32'h80, 32'h1234_5678, 32'hE3A0_0001, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 6,
                32'h06, 32'h00, 32'h00, 32'h08, 32'h24, 32'h0, 32'hE3A0_0001, 32'h6D};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 10,
                32'h66, 32'h00, 32'h08, 32'h80, 32'h20, 32'h0, 32'h61, 32'h91};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 6,
                32'h06, 32'h00, 32'h08, 32'h00, 32'h14, 32'h0, 32'h3D, 32'h91};
`ifdef MEM_ARB_CPU_PRIORITY_EN
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b1, 1'b0, 32'h1C, 32'h0, 10,
                32'h66, 32'h00, 32'h08, 32'h80, 32'h18, 32'h0, 32'h49, 32'h55};
`else
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b1, 1'b0, 32'h1C, 32'h0, 10,
                32'h66, 32'h00, 32'h80, 32'h08, 32'h1C, 32'h0, 32'h49, 32'h55};
`endif

    // Reset state.
    do_reset();
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_mem_en", 32'(mem_en), 32'h0);
    check("reset_acks", {30'h0, cpu_ack, dma_ack}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);

    // Vector table.
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else @(negedge clk);
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
      dma_req = vecs[i].dreq; dma_we = vecs[i].dwe; dma_addr = vecs[i].daddr; dma_wdata = vecs[i].dwdata;
      run_seq(vecs[i].n, 1'b0, 1'b0, -1, en_t, we_t, ca_t, da_t, a1, w1);
      check($sformatf("vec%0d_mem_en", i), en_t, vecs[i].en_m);
      check($sformatf("vec%0d_mem_we", i), we_t, vecs[i].we_m);
      check($sformatf("vec%0d_cpu_ack", i), ca_t, vecs[i].ca_m);
      check($sformatf("vec%0d_dma_ack", i), da_t, vecs[i].da_m);
      check($sformatf("vec%0d_mem_addr", i), a1, vecs[i].addr1);
      check($sformatf("vec%0d_mem_wdata", i), w1, vecs[i].wdata1);
      check($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].crd);
      check($sformatf("vec%0d_dma_rdata", i), dma_rdata, vecs[i].drd);
    end

    // Reset clears captured read data and the address latch.
    do_reset();
    check("rst_clear_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_clear_dma_rdata", dma_rdata, 32'h0);
    check("rst_clear_mem_addr", mem_addr, 32'h0);

    // cpu_req dropped in cycle 1: transaction still completes.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    run_seq(6, 1'b0, 1'b0, 1, en_t, we_t, ca_t, da_t, a1, w1);
    check("drop_mem_en", en_t, 32'h06);
    check("drop_cpu_ack", ca_t, 32'h08);
    check("drop_cpu_rdata", cpu_rdata, 32'hE3A0_0001);

    // Reset in cycle 2 of ACCESS.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h24;
    run_seq(3, 1'b1, 1'b0, -1, en_t, we_t, ca_t, da_t, a1, w1);
    check("midrst_pre_mem_en", en_t, 32'h06);
    reset = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("midrst_mem_en_async", 32'(mem_en), 32'h0);
    check("midrst_busy_async", 32'(busy), 32'h0);
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) reset = 1'b0;
      acc = acc | {30'h0, cpu_ack, dma_ack};
    end
    check("midrst_no_ack", acc, 32'h0);
    check("midrst_cpu_rdata", cpu_rdata, 32'h0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h28;
    run_seq(6, 1'b0, 1'b0, -1, en_t, we_t, ca_t, da_t, a1, w1);
    check("postrst_mem_en", en_t, 32'h06);
    check("postrst_cpu_ack", ca_t, 32'h08);
    check("postrst_cpu_rdata", cpu_rdata, 32'h79);

    // Back-to-back CPU reads with req held high.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    run_seq(12, 1'b1, 1'b0, -1, en_t, we_t, ca_t, da_t, a1, w1);
    check("b2b_mem_en", en_t, 32'h666);
    check("b2b_cpu_ack", ca_t, 32'h888);
    check("b2b_no_adjacent", ca_t & (ca_t << 1), 32'h0);

    // Both requesters held high from reset.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h14;
    dma_req = 1'b1; dma_addr = 32'h18;
    run_seq(20, 1'b1, 1'b1, -1, en_t, we_t, ca_t, da_t, a1, w1);
`ifdef MEM_ARB_CPU_PRIORITY_EN
    check("hold_cpu_ack", ca_t, 32'h88888);
    check("hold_dma_ack", da_t, 32'h0);
`else
    check("hold_cpu_ack", ca_t, 32'h80808);
    check("hold_dma_ack", da_t, 32'h8080);
`endif
    check("hold_ack_exclusive", ca_t & da_t, 32'h0);

    // Randomized traffic against a transaction-level timing model.
    do_reset();
    acc_start = -100; ack_at = -100; free_at = 0;
    g = 1'b0; last_dma = 1'b1; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    c_pend = 1'b0; d_pend = 1'b0; exp_crd = '0; exp_drd = '0;
    for (int t = 0; t < 600; t++) begin
      if (t > 0) @(negedge clk);
      exp_en = (t >= acc_start) && (t < acc_start + LAT);
      exp_ca = (t == ack_at) && !g;
      exp_da = (t == ack_at) && g;
      if ((t == ack_at) && !m_we) begin
        if (!g) exp_crd = mem_fn(m_addr);
        else    exp_drd = mem_fn(m_addr);
      end
      check("rnd_mem_en", 32'(mem_en), 32'(exp_en));
      check("rnd_mem_we", 32'(mem_we), 32'(exp_en && m_we));
      check("rnd_cpu_ack", 32'(cpu_ack), 32'(exp_ca));
      check("rnd_dma_ack", 32'(dma_ack), 32'(exp_da));
      check("rnd_busy", 32'(busy), 32'((t >= acc_start) && (t <= ack_at)));
      check("rnd_cpu_rdata", cpu_rdata, exp_crd);
      check("rnd_dma_rdata", dma_rdata, exp_drd);
      if (exp_en) begin
        check("rnd_mem_addr", mem_addr, m_addr);
        check("rnd_mem_wdata", mem_wdata, m_wdata);
      end

      if (exp_ca) begin
        c_pend = 1'b0; cpu_req = 1'b0;
      end else if (c_pend && !g && (ack_at > t) && ($urandom % 4 == 0)) begin
        cpu_req = 1'b0;
      end else if (!c_pend && ($urandom % 3 == 0)) begin
        c_pend = 1'b1; cpu_req = 1'b1; cpu_we = 1'($urandom % 2);
        cpu_addr = $urandom & 32'hFFFF_FFFC; cpu_wdata = $urandom;
      end
      if (exp_da) begin
        d_pend = 1'b0; dma_req = 1'b0;
      end else if (d_pend && g && (ack_at > t) && ($urandom % 4 == 0)) begin
        dma_req = 1'b0;
      end else if (!d_pend && ($urandom % 3 == 0)) begin
        d_pend = 1'b1; dma_req = 1'b1; dma_we = 1'($urandom % 2);
        dma_addr = $urandom & 32'hFFFF_FFFC; dma_wdata = $urandom;
      end

      if ((t >= free_at) && (cpu_req || dma_req)) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
        g = !cpu_req;
`else
        if (cpu_req && dma_req) g = !last_dma;
        else                    g = !cpu_req;
`endif
        last_dma  = g;
        acc_start = t + 1;
        ack_at    = t + LAT + 1;
        free_at   = t + LAT + 2;
        m_we      = g ? dma_we    : cpu_we;
        m_addr    = g ? dma_addr  : cpu_addr;
        m_wdata   = g ? dma_wdata : cpu_wdata;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
